// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: holds dispatched instructions until both source
// operands are woken by the CDB, then offers the oldest ready entry to the functional unit.
module rs_issue_scheduler #(
    parameter int unsigned NUM_ENTRIES         = 4,
    parameter int unsigned REG_FILE_ADDR_WIDTH = 7,
    localparam int unsigned SLOT_W             = $clog2(NUM_ENTRIES)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,

    input  logic                           dispatch_valid,
    output logic                           dispatch_ready,
    input  logic [31:0]                    dispatch_instr,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dispatch_rd,
    input  logic                           dispatch_rs1_ready,
    input  logic                           dispatch_rs2_ready,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dispatch_rs1,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dispatch_rs2,

    input  logic                           cdb_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] cdb_tag,

    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [31:0]                    issue_instr,
    output logic [REG_FILE_ADDR_WIDTH-1:0] issue_rd,
    output logic [SLOT_W-1:0]              issue_slot,

    output logic [SLOT_W:0]                occupancy
);

    localparam int unsigned N  = NUM_ENTRIES;
    localparam int unsigned AW = REG_FILE_ADDR_WIDTH;

    logic [N-1:0] valid_q, valid_d;
    logic [N-1:0] rs1_rdy_q, rs1_rdy_d;
    logic [N-1:0] rs2_rdy_q, rs2_rdy_d;
    // older_q[i][j] = entry i was dispatched before entry j; a pairwise matrix never wraps.
    logic [N-1:0][N-1:0] older_q, older_d;

    logic [31:0]   instr_q [N];
    logic [AW-1:0] rd_q    [N];
    logic [AW-1:0] rs1_q   [N];
    logic [AW-1:0] rs2_q   [N];

    logic [N-1:0]      ready_vec;
    logic [N-1:0]      oldest_vec;
    logic [SLOT_W-1:0] disp_idx;
    logic [SLOT_W-1:0] issue_idx;
    logic              disp_fire;
    logic              issue_fire;

    always_comb begin
        disp_idx       = '0;
        dispatch_ready = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                disp_idx       = SLOT_W'(i);
                dispatch_ready = 1'b1;
            end
        end
    end

    always_comb begin
        ready_vec  = valid_q & rs1_rdy_q & rs2_rdy_q;
        oldest_vec = ready_vec;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i && ready_vec[j] && older_q[j][i]) begin
                    oldest_vec[i] = 1'b0;
                end
            end
        end
        issue_idx   = '0;
        issue_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (oldest_vec[i]) begin
                issue_idx   = SLOT_W'(i);
                issue_valid = 1'b1;
            end
        end
    end

    assign issue_instr = issue_valid ? instr_q[issue_idx] : '0;
    assign issue_rd    = issue_valid ? rd_q[issue_idx] : '0;
    assign issue_slot  = issue_idx;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < N; i++) begin
            occupancy = occupancy + (SLOT_W + 1)'(valid_q[i]);
        end
    end

    assign disp_fire  = dispatch_valid && dispatch_ready;
    assign issue_fire = issue_valid && issue_ready;

    always_comb begin
        valid_d   = valid_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        older_d   = older_q;
        if (cdb_valid) begin
            for (int i = 0; i < N; i++) begin
                if (valid_q[i] && rs1_q[i] == cdb_tag) rs1_rdy_d[i] = 1'b1;
                if (valid_q[i] && rs2_q[i] == cdb_tag) rs2_rdy_d[i] = 1'b1;
            end
        end
        if (issue_fire) begin
            valid_d[issue_idx] = 1'b0;
        end
        if (disp_fire) begin
            valid_d[disp_idx]   = 1'b1;
            rs1_rdy_d[disp_idx] = dispatch_rs1_ready || (cdb_valid && dispatch_rs1 == cdb_tag);
            rs2_rdy_d[disp_idx] = dispatch_rs2_ready || (cdb_valid && dispatch_rs2 == cdb_tag);
            // New entry is younger than every other entry, valid or not.
            older_d[disp_idx] = '0;
            for (int i = 0; i < N; i++) begin
                older_d[i][disp_idx] = (SLOT_W'(i) != disp_idx);
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            older_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            older_q   <= older_d;
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clock) begin
        if (disp_fire) begin
            instr_q[disp_idx] <= dispatch_instr;
            rd_q[disp_idx]    <= dispatch_rd;
            rs1_q[disp_idx]   <= dispatch_rs1;
            rs2_q[disp_idx]   <= dispatch_rs2;
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: expected issues are queued by the stimulus and
// compared by a monitor whenever an issue handshake completes.
module tb_rs_issue_scheduler;

    localparam int N  = 4;
    localparam int AW = 7;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          dispatch_valid = 1'b0;
    logic          dispatch_ready;
    logic [31:0]   dispatch_instr = '0;
    logic [AW-1:0] dispatch_rd = '0;
    logic          dispatch_rs1_ready = 1'b0;
    logic          dispatch_rs2_ready = 1'b0;
    logic [AW-1:0] dispatch_rs1 = '0;
    logic [AW-1:0] dispatch_rs2 = '0;
    logic          cdb_valid = 1'b0;
    logic [AW-1:0] cdb_tag = '0;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [31:0]   issue_instr;
    logic [AW-1:0] issue_rd;
    logic [1:0]    issue_slot;
    logic [2:0]    occupancy;

    rs_issue_scheduler #(
        .NUM_ENTRIES         (N),
        .REG_FILE_ADDR_WIDTH (AW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_ready     (dispatch_ready),
        .dispatch_instr     (dispatch_instr),
        .dispatch_rd        (dispatch_rd),
        .dispatch_rs1_ready (dispatch_rs1_ready),
        .dispatch_rs2_ready (dispatch_rs2_ready),
        .dispatch_rs1       (dispatch_rs1),
        .dispatch_rs2       (dispatch_rs2),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_instr        (issue_instr),
        .issue_rd           (issue_rd),
        .issue_slot         (issue_slot),
        .occupancy          (occupancy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]    slot;
        logic [31:0]   instr;
        logic [AW-1:0] rd;
    } issue_t;

    issue_t exp_q[$];
    int     total = 0;
    int     bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic dispatch(input logic [31:0] instr, input logic [AW-1:0] rd,
                            input logic [AW-1:0] rs1, input logic r1,
                            input logic [AW-1:0] rs2, input logic r2);
        dispatch_valid     = 1'b1;
        dispatch_instr     = instr;
        dispatch_rd        = rd;
        dispatch_rs1       = rs1;
        dispatch_rs1_ready = r1;
        dispatch_rs2       = rs2;
        dispatch_rs2_ready = r2;
        step();
        dispatch_valid = 1'b0;
    endtask

    task automatic cdb(input logic [AW-1:0] tag);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        step();
        cdb_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [1:0] slot, input logic [31:0] instr,
                                input logic [AW-1:0] rd);
        exp_q.push_back('{slot: slot, instr: instr, rd: rd});
    endtask

    task automatic issue_cycles(input int n);
        issue_ready = 1'b1;
        repeat (n) step();
        issue_ready = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_dispatch_ready"}, 32'(dispatch_ready), 32'd1);
        check({name, "_issue_valid"}, 32'(issue_valid), 32'd0);
        check({name, "_issue_instr"}, issue_instr, 32'd0);
        check({name, "_issue_rd"}, 32'(issue_rd), 32'd0);
        check({name, "_issue_slot"}, 32'(issue_slot), 32'd0);
        check({name, "_occupancy"}, 32'(occupancy), 32'd0);
    endtask

    // Monitor: every completed issue handshake must match the head of the queue.
    always @(negedge clock) begin
        issue_t got;
        issue_t e;
        if (!reset && issue_valid && issue_ready) begin
            got   = '{slot: issue_slot, instr: issue_instr, rd: issue_rd};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue: got slot=%0d instr=0x%0h rd=%0d want none",
                         got.slot, got.instr, got.rd);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL issue: got slot=%0d instr=0x%0h rd=%0d want slot=%0d instr=0x%0h rd=%0d",
                             got.slot, got.instr, got.rd, e.slot, e.instr, e.rd);
                end
            end
        end
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        check_idle("reset");

        // Single ready dispatch is offered next cycle
        dispatch(32'h0000_0013, 7'd1, 7'd0, 1'b1, 7'd0, 1'b1);
        check("a_issue_valid", 32'(issue_valid), 32'd1);
        check("a_issue_slot", 32'(issue_slot), 32'd0);
        check("a_issue_instr", issue_instr, 32'h0000_0013);
        check("a_occupancy", 32'(occupancy), 32'd1);
        expect_issue(2'd0, 32'h0000_0013, 7'd1);
        issue_cycles(1);
        check("a_drained_occ", 32'(occupancy), 32'd0);

        // issue_ready with nothing ready has no effect
        issue_cycles(1);
        check("idle_issue_occ", 32'(occupancy), 32'd0);

        // Fill the station with rs1-pending entries
        for (int k = 0; k < 4; k++) begin
            dispatch(32'h100 + 32'(k), 7'(20 + k), 7'(5 + k), 1'b0, 7'd0, 1'b1);
        end
        check("full_dispatch_ready", 32'(dispatch_ready), 32'd0);
        check("full_occupancy", 32'(occupancy), 32'd4);
        dispatch(32'hdead, 7'd99, 7'd0, 1'b1, 7'd0, 1'b1);
        check("full_ignored_occ", 32'(occupancy), 32'd4);
        check("full_ignored_valid", 32'(issue_valid), 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 7'd7;
        #1;
        check("no_bypass_valid", 32'(issue_valid), 32'd0);
        step();
        cdb_valid = 1'b0;
        check("wake7_valid", 32'(issue_valid), 32'd1);
        check("wake7_slot", 32'(issue_slot), 32'd2);

        // Full station: issue and dispatch together; dispatch must not be taken
        dispatch_valid     = 1'b1;
        dispatch_instr     = 32'hbeef;
        dispatch_rd        = 7'd30;
        dispatch_rs1_ready = 1'b1;
        dispatch_rs2_ready = 1'b1;
        expect_issue(2'd2, 32'h102, 7'd22);
        issue_cycles(1);
        dispatch_valid = 1'b0;
        check("full_swap_occ", 32'(occupancy), 32'd3);
        check("full_swap_dready", 32'(dispatch_ready), 32'd1);
        check("full_swap_ivalid", 32'(issue_valid), 32'd0);

        // Refilled slot 2 is youngest; waking slot 0 must win on age
        dispatch(32'hbeef, 7'd30, 7'd0, 1'b1, 7'd0, 1'b1);
        check("refill_occ", 32'(occupancy), 32'd4);
        cdb(7'd5);
        expect_issue(2'd0, 32'h100, 7'd20);
        expect_issue(2'd2, 32'hbeef, 7'd30);
        issue_cycles(2);
        check("after_two_occ", 32'(occupancy), 32'd2);
        cdb(7'd8);
        cdb(7'd6);
        expect_issue(2'd1, 32'h101, 7'd21);
        expect_issue(2'd3, 32'h103, 7'd23);
        issue_cycles(2);
        check("empty_again_occ", 32'(occupancy), 32'd0);

        // Later wake of an older entry still issues first
        dispatch(32'h200, 7'd40, 7'd9, 1'b0, 7'd0, 1'b1);
        dispatch(32'h201, 7'd41, 7'd10, 1'b0, 7'd0, 1'b1);
        cdb(7'd10);
        cdb(7'd9);
        check("xy_issue_slot", 32'(issue_slot), 32'd0);
        check("xy_issue_instr", issue_instr, 32'h200);
        // Issue X while dispatching Z: Z lands in slot 2, then W refills slot 0
        expect_issue(2'd0, 32'h200, 7'd40);
        issue_ready = 1'b1;
        dispatch(32'h202, 7'd42, 7'd0, 1'b1, 7'd0, 1'b1);
        issue_ready = 1'b0;
        dispatch(32'h203, 7'd43, 7'd0, 1'b1, 7'd0, 1'b1);
        check("yzw_occ", 32'(occupancy), 32'd3);
        expect_issue(2'd1, 32'h201, 7'd41);
        expect_issue(2'd2, 32'h202, 7'd42);
        expect_issue(2'd0, 32'h203, 7'd43);
        issue_cycles(3);

        // Dispatch coinciding with its operand's broadcast stores it ready
        cdb_valid = 1'b1;
        cdb_tag   = 7'd12;
        dispatch(32'h300, 7'd50, 7'd0, 1'b1, 7'd12, 1'b0);
        cdb_valid = 1'b0;
        check("cdb_capture_valid", 32'(issue_valid), 32'd1);
        expect_issue(2'd0, 32'h300, 7'd50);
        issue_cycles(1);

        // Both operands waiting on the same tag wake together
        dispatch(32'h301, 7'd51, 7'd13, 1'b0, 7'd13, 1'b0);
        check("dual_wait_valid", 32'(issue_valid), 32'd0);
        cdb(7'd13);
        check("dual_wake_valid", 32'(issue_valid), 32'd1);
        expect_issue(2'd0, 32'h301, 7'd51);
        issue_cycles(1);

        // Flush beats a concurrent dispatch
        for (int k = 0; k < 3; k++) begin
            dispatch(32'h400 + 32'(k), 7'(60 + k), 7'd0, 1'b1, 7'd0, 1'b1);
        end
        check("preflush_occ", 32'(occupancy), 32'd3);
        flush = 1'b1;
        dispatch(32'h4ff, 7'd70, 7'd0, 1'b1, 7'd0, 1'b1);
        flush = 1'b0;
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_ivalid", 32'(issue_valid), 32'd0);

        // Reset with entries pending beats dispatch and issue
        dispatch(32'h500, 7'd80, 7'd0, 1'b1, 7'd0, 1'b1);
        dispatch(32'h501, 7'd81, 7'd0, 1'b1, 7'd0, 1'b1);
        reset       = 1'b1;
        issue_ready = 1'b1;
        dispatch(32'h5ff, 7'd82, 7'd0, 1'b1, 7'd0, 1'b1);
        reset       = 1'b0;
        issue_ready = 1'b0;
        check_idle("midreset");

        // Station works normally after reset
        dispatch(32'h600, 7'd90, 7'd0, 1'b1, 7'd0, 1'b1);
        expect_issue(2'd0, 32'h600, 7'd90);
        issue_cycles(1);
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_issue_scheduler.md
RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, giving the number of station entries; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter REG_FILE_ADDR_WIDTH, default 7, giving the physical register tag width.
REQ-003 SHALL have ports: clock  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: flush  in  1  discard all entries; dispatch_valid  in  1  new instruction offered; dispatch_ready  out  1  a free entry exists.
REQ-005 SHALL have ports: dispatch_instr  in  32  instruction word; dispatch_rd  in  REG_FILE_ADDR_WIDTH  destination tag.
REQ-006 SHALL have ports: dispatch_rs1_ready  in  1  and dispatch_rs2_ready  in  1  operand already available; dispatch_rs1  in  REG_FILE_ADDR_WIDTH  and dispatch_rs2  in  REG_FILE_ADDR_WIDTH  source tags.
REQ-007 SHALL have ports: cdb_valid  in  1  broadcast valid; cdb_tag  in  REG_FILE_ADDR_WIDTH  completing tag.
REQ-008 SHALL have ports: issue_valid  out  1  ready entry offered; issue_ready  in  1  functional unit accepts; issue_instr  out  32; issue_rd  out  REG_FILE_ADDR_WIDTH; issue_slot  out  log2(NUM_ENTRIES)  entry index.
REQ-009 SHALL have port occupancy  out  log2(NUM_ENTRIES)+1  count of valid entries.

Function
REQ-010 Each entry SHALL hold valid, instr, rd, rs1, rs1_ready, rs2, rs2_ready, plus relative dispatch order.
REQ-011 dispatch_ready SHALL be combinational: 1 iff at least one entry is invalid in the current state.
REQ-012 Dispatch fires on dispatch_valid && dispatch_ready; the lowest-indexed invalid entry is written at the edge and becomes valid and youngest.
REQ-013 dispatch_valid while dispatch_ready=0 SHALL have no effect; no entry or ordering changes.
REQ-014 Entry ready = valid && rs1_ready && rs2_ready.
REQ-015 issue_valid SHALL be combinational: 1 iff any entry is ready; issue_* SHALL show the oldest ready entry, oldest meaning earliest dispatched.
REQ-016 When issue_valid=0, issue_instr, issue_rd and issue_slot SHALL be 0.
REQ-017 Issue fires on issue_valid && issue_ready; the selected entry becomes invalid at the edge; relative order of the remaining entries is kept.
REQ-018 On cdb_valid, every valid entry with rs1==cdb_tag SHALL set rs1_ready at the edge; the same rule applies to rs2. Both operands may wake in one cycle.
REQ-019 Wakeup SHALL NOT bypass: an entry woken in cycle N can first be offered in cycle N+1.
REQ-020 A dispatch whose rs1 or rs2 equals cdb_tag while cdb_valid is high SHALL store that operand as ready.
REQ-021 Dispatch and issue in the same cycle SHALL both take effect; the slot freed by issue is not available to that cycle's dispatch.
REQ-022 occupancy next = occupancy + dispatch_fire - issue_fire; it SHALL never exceed NUM_ENTRIES or go below 0.
REQ-023 When flush=1, all entries SHALL become invalid at the edge; flush overrides dispatch, issue and wakeup in that cycle; occupancy becomes 0.
REQ-024 issue_ready=1 while issue_valid=0 SHALL have no effect.
REQ-025 Dispatch order SHALL stay correct across unlimited dispatch/issue sequences; no counter wrap may corrupt age.

Reset
REQ-026 When reset=1 at a rising edge, all entries SHALL become invalid and age state cleared; reset has priority over flush, dispatch, issue and cdb.
REQ-027 After reset: dispatch_ready=1, issue_valid=0, issue_instr=0, issue_rd=0, issue_slot=0, occupancy=0.
REQ-028 Reset asserted mid-operation with entries pending SHALL discard them; no issue_valid in the cycle after reset.

Verification
REQ-029 Dispatch A (instr 0x00000013, both ready) with issue_ready=0 -> next cycle issue_valid=1, issue_slot=0, issue_instr=0x00000013, occupancy=1.
REQ-030 Dispatch 4 entries, rs1 not ready, rs1 tags 5,6,7,8 -> dispatch_ready=0, occupancy=4; 5th dispatch ignored; cdb_tag=7 -> next cycle issue_slot=2.
REQ-031 Dispatch X (slot 0, waits tag 9) then Y (slot 1, waits tag 10); cdb 10 then cdb 9; hold issue_ready=0 -> Y and X both ready, issue_slot=0 (X oldest).
REQ-032 Dispatch with dispatch_rs2=12, rs2_ready=0, same cycle cdb_valid=1 cdb_tag=12, rs1 ready -> next cycle issue_valid=1.
REQ-033 Full station, issue_ready=1 and dispatch_valid=1 same cycle -> one entry issued, dispatch not taken, occupancy 4->3, dispatch_ready=1 next cycle.
REQ-034 Three entries valid, flush=1 together with dispatch_valid=1 -> next cycle occupancy=0, issue_valid=0; reset with entries pending -> same outputs as REQ-027.
